// File: rtl/matrix_row_scanner_pkg.sv
// Shared constants, state encoding and row-drive helper for the 5x7 dot-matrix row scanner.
package matrix_row_scanner_pkg;

  localparam int         NUM_ROWS = 7;
  localparam int         NUM_COLS = 5;
  localparam logic [6:0] ROWS_OFF = 7'b1111111;
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // Active-low one-hot row drive for a 0-based row index.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [2:0] idx);
    row_drive = ROWS_OFF & ~(7'b0000001 << idx);
  endfunction

endpackage

// File: rtl/matrix_row_scanner_if.sv
// Pattern inputs and matrix pin outputs of the row scanner, grouped as one bundle.
interface matrix_row_scanner_if;
  import matrix_row_scanner_pkg::*;

  logic                en;
  logic [NUM_COLS-1:0] cl1;
  logic [NUM_COLS-1:0] cl2;
  logic [NUM_COLS-1:0] cl3;
  logic [NUM_COLS-1:0] cl4;
  logic [NUM_COLS-1:0] cl5;
  logic [NUM_COLS-1:0] cl6;
  logic [NUM_COLS-1:0] cl7;
  logic [NUM_ROWS-1:0] row_n;
  logic [NUM_COLS-1:0] col;
  logic                frame_done;

  modport master (
    output en, cl1, cl2, cl3, cl4, cl5, cl6, cl7,
    input  row_n, col, frame_done
  );

  modport slave (
    input  en, cl1, cl2, cl3, cl4, cl5, cl6, cl7,
    output row_n, col, frame_done
  );

endinterface

// File: rtl/matrix_row_scanner_dwell.sv
// Loadable down-counter timing both the lit and blanking phases; saturates at zero.
module scan_dwell_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Dwell count register: load wins, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/matrix_row_scanner.sv
// Latches seven row patterns per frame and multiplexes them onto the matrix one row at a time,
// with an optional all-off gap between rows.
module matrix_row_scanner
  import matrix_row_scanner_pkg::*;
#(
  parameter int DIV_COUNT    = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  matrix_row_scanner_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

  state_t                             state_r;
  logic [2:0]                         row_idx_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  shadow_r;
  logic [NUM_ROWS-1:0]                row_n_r;
  logic [NUM_COLS-1:0]                col_r;
  logic                               frame_done_r;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  capture_s;
  logic [2:0]                         nxt_idx_s;
  logic                               last_s;
  logic                               row_done_s;
  logic                               zero_s;
  logic                               load_s;
  logic [CNT_W-1:0]                   load_value_s;

  scan_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_value (load_value_s),
    .zero       (zero_s)
  );

  // Phase-end detection and dwell counter reload for whichever phase comes next.
  always_comb begin
    capture_s  = {bus.cl7, bus.cl6, bus.cl5, bus.cl4, bus.cl3, bus.cl2, bus.cl1};
    nxt_idx_s  = row_idx_r + 3'd1;
    last_s     = (row_idx_r == LAST_ROW);
    row_done_s = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        load_s = bus.en;
      end
      S_SHOW: begin
        row_done_s = zero_s && !HAS_BLANK;
        load_s     = zero_s;
      end
      S_BLANK: begin
        row_done_s = zero_s;
        load_s     = zero_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
    if ((state_r == S_SHOW) && HAS_BLANK) begin
      load_value_s = BLANK_LOAD;
    end else if (row_done_s && last_s && !bus.en) begin
      load_value_s = {CNT_W{1'b0}};
    end else begin
      load_value_s = DIV_LOAD;
    end
  end

  // Scan FSM; row/column drives are computed for the state being entered so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      row_idx_r    <= 3'd0;
      shadow_r     <= '{default: {NUM_COLS{1'b0}}};
      row_n_r      <= ROWS_OFF;
      col_r        <= {NUM_COLS{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (row_done_s) begin
        if (!last_s) begin
          row_idx_r <= nxt_idx_s;
          state_r   <= S_SHOW;
          row_n_r   <= row_drive(nxt_idx_s);
          col_r     <= shadow_r[nxt_idx_s];
        end else begin
          frame_done_r <= 1'b1;
          row_idx_r    <= 3'd0;
          if (bus.en) begin
            shadow_r <= capture_s;
            state_r  <= S_SHOW;
            row_n_r  <= row_drive(3'd0);
            col_r    <= capture_s[0];
          end else begin
            state_r <= S_IDLE;
            row_n_r <= ROWS_OFF;
            col_r   <= {NUM_COLS{1'b0}};
          end
        end
      end else begin
        case (state_r)
          S_IDLE: begin
            if (bus.en) begin
              shadow_r  <= capture_s;
              row_idx_r <= 3'd0;
              state_r   <= S_SHOW;
              row_n_r   <= row_drive(3'd0);
              col_r     <= capture_s[0];
            end else begin
              row_n_r <= ROWS_OFF;
              col_r   <= {NUM_COLS{1'b0}};
            end
          end
          S_SHOW: begin
            if (zero_s) begin
              state_r <= S_BLANK;
              row_n_r <= ROWS_OFF;
              col_r   <= {NUM_COLS{1'b0}};
            end else begin
              state_r <= S_SHOW;
            end
          end
          S_BLANK: begin
            state_r <= S_BLANK;
          end
          default: begin
            state_r   <= S_IDLE;
            row_idx_r <= 3'd0;
            row_n_r   <= ROWS_OFF;
            col_r     <= {NUM_COLS{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.row_n      = row_n_r;
  assign bus.col        = col_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench: a segment table walks four frames of a blanked scanner; hand sequences cover
// asynchronous reset mid-frame and a scanner with blanking disabled.
module tb_matrix_row_scanner;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  matrix_row_scanner_if bus_a ();
  matrix_row_scanner_if bus_b ();

  matrix_row_scanner #(.DIV_COUNT(4), .BLANK_CYCLES(2), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  matrix_row_scanner #(.DIV_COUNT(1), .BLANK_CYCLES(0), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      row_n;
    logic [4:0]      col;
    logic            fd_first;
    int              len;
    logic            act;
    logic            act_en;
    logic [6:0][4:0] act_cl;
  } seg_t;

  seg_t            segs [64];
  int              n_segs;
  logic [6:0]      lit_rows [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F};
  logic [6:0][4:0] pa;
  logic [6:0][4:0] pb;
  logic [6:0][4:0] zz;
  logic [6:0][4:0] exp_frame [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_a(input logic e, input logic [6:0][4:0] p);
    bus_a.en  = e;
    bus_a.cl1 = p[0];
    bus_a.cl2 = p[1];
    bus_a.cl3 = p[2];
    bus_a.cl4 = p[3];
    bus_a.cl5 = p[4];
    bus_a.cl6 = p[5];
    bus_a.cl7 = p[6];
  endtask

  task automatic add_seg(input logic [6:0] rn, input logic [4:0] c, input logic fd, input int len,
                         input logic act, input logic ae, input logic [6:0][4:0] acl);
    segs[n_segs].row_n    = rn;
    segs[n_segs].col      = c;
    segs[n_segs].fd_first = fd;
    segs[n_segs].len      = len;
    segs[n_segs].act      = act;
    segs[n_segs].act_en   = ae;
    segs[n_segs].act_cl   = acl;
    n_segs++;
  endtask

  initial begin
    logic            act;
    logic            ae;
    logic [6:0][4:0] acl;

    tests  = 0;
    failed = 0;
    n_segs = 0;
    pa = {5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h1F, 5'h11};
    pb = {5'h1F, 5'h19, 5'h03, 5'h1B, 5'h0E, 5'h15, 5'h0A};
    zz = '0;
    exp_frame[0] = pa;
    exp_frame[1] = pa;
    exp_frame[2] = zz;
    exp_frame[3] = pb;

    // Frame 2 row 4: patterns go to zero; frame 3: new patterns at row 1, en toggled off/on;
    // frame 4 row 2: en dropped, so the frame finishes and the scanner idles.
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 7; r++) begin
        act = 1'b0;
        ae  = 1'b1;
        acl = pa;
        if (f == 1 && r == 3) begin
          act = 1'b1; ae = 1'b1; acl = zz;
        end else if (f == 2 && r == 0) begin
          act = 1'b1; ae = 1'b1; acl = pb;
        end else if (f == 2 && r == 2) begin
          act = 1'b1; ae = 1'b0; acl = pb;
        end else if (f == 2 && r == 4) begin
          act = 1'b1; ae = 1'b1; acl = pb;
        end else if (f == 3 && r == 1) begin
          act = 1'b1; ae = 1'b0; acl = pb;
        end
        add_seg(lit_rows[r], exp_frame[f][r], (f > 0) && (r == 0), 4, act, ae, acl);
        add_seg(7'h7F, 5'h00, 1'b0, 2, 1'b0, 1'b0, zz);
      end
    end
    add_seg(7'h7F, 5'h00, 1'b1, 4, 1'b0, 1'b0, zz);

    rst = 1'b1;
    drive_a(1'b1, pa);
    bus_b.en  = 1'b0;
    bus_b.cl1 = pa[0]; bus_b.cl2 = pa[1]; bus_b.cl3 = pa[2]; bus_b.cl4 = pa[3];
    bus_b.cl5 = pa[4]; bus_b.cl6 = pa[5]; bus_b.cl7 = pa[6];

    repeat (3) @(negedge clk);
    check("reset_a_row_n", 32'(bus_a.row_n), 32'h7F);
    check("reset_a_col", 32'(bus_a.col), 32'h0);
    check("reset_a_fd", 32'(bus_a.frame_done), 32'h0);
    check("reset_b_row_n", 32'(bus_b.row_n), 32'h7F);
    check("reset_b_col", 32'(bus_b.col), 32'h0);
    rst = 1'b0;

    for (int s = 0; s < n_segs; s++) begin
      for (int c = 0; c < segs[s].len; c++) begin
        @(negedge clk);
        check($sformatf("seg%0d_c%0d_row_n", s, c), 32'(bus_a.row_n), 32'(segs[s].row_n));
        check($sformatf("seg%0d_c%0d_col", s, c), 32'(bus_a.col), 32'(segs[s].col));
        check($sformatf("seg%0d_c%0d_fd", s, c), 32'(bus_a.frame_done),
              32'((c == 0) ? segs[s].fd_first : 1'b0));
        if (c == 0 && segs[s].act) begin
          drive_a(segs[s].act_en, segs[s].act_cl);
        end
      end
    end

    // Reset while row 5 is lit, then restart from row 1.
    drive_a(1'b1, pa);
    @(negedge clk);
    check("restart_row1_row_n", 32'(bus_a.row_n), 32'h7E);
    check("restart_row1_col", 32'(bus_a.col), 32'h11);
    repeat (25) @(negedge clk);
    check("row5_lit_row_n", 32'(bus_a.row_n), 32'h6F);
    check("row5_lit_col", 32'(bus_a.col), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("async_rst_row_n", 32'(bus_a.row_n), 32'h7F);
    check("async_rst_col", 32'(bus_a.col), 32'h0);
    check("async_rst_fd", 32'(bus_a.frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_row_n", 32'(bus_a.row_n), 32'h7E);
    check("after_rst_col", 32'(bus_a.col), 32'h11);

    // Unblanked scanner: one row per cycle, frame_done every 7 cycles, graceful stop.
    bus_b.en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      check($sformatf("nb_k%0d_row_n", k), 32'(bus_b.row_n), 32'(lit_rows[k % 7]));
      check($sformatf("nb_k%0d_col", k), 32'(bus_b.col), 32'(pa[k % 7]));
      check($sformatf("nb_k%0d_fd", k), 32'(bus_b.frame_done), 32'((k % 7 == 0) && (k > 0)));
    end
    bus_b.en = 1'b0;
    @(negedge clk);
    check("nb_stop_row_n", 32'(bus_b.row_n), 32'h7F);
    check("nb_stop_col", 32'(bus_b.col), 32'h0);
    check("nb_stop_fd", 32'(bus_b.frame_done), 32'h1);
    @(negedge clk);
    check("nb_idle_row_n", 32'(bus_b.row_n), 32'h7F);
    check("nb_idle_fd", 32'(bus_b.frame_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
